// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS controller, datapath and ALU decoder.
// Holds state codes, opcodes, ALUSrcB/ALUOp/PCSrc encodings and the control vector type.
// Optional feature macro CTRL_BNE_EN: when defined, bne (000101) is a legal branch.
package multicycle_control_fsm_pkg;

`ifdef CTRL_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   // State encoding; codes 12..15 are unused and fall back to FETCH.
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctrl_t;

   // State entered after DECODE; FETCH means the opcode is not supported.
   function automatic logic [3:0] decode_target(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: return S_MEMADR;
         OP_RTYPE:     return S_EXECUTE;
         OP_BEQ:       return S_BRANCH;
         OP_BNE:       return BNE_EN ? S_BRANCH : S_FETCH;
         OP_ADDI:      return S_ADDIEXEC;
         OP_J:         return S_JUMP;
         default:      return S_FETCH;
      endcase
   endfunction

   function automatic logic is_bne(input logic [5:0] op);
      return BNE_EN && (op == OP_BNE);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_output_decode.sv
// Combinational map from (state, zero, mem_ready, opcode) to the control vector.
// Ports: state/zero/mem_ready/opcode in, ctrl (packed ctrl_t) out.
// mem_ready here is the effective ready (already forced to 1 when waits are disabled).
module ctrl_output_decode
   import multicycle_control_fsm_pkg::*;
(
   input  logic [3:0] state,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic [5:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            // PC and IR only load on the cycle the fetch actually completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH2;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = (decode_target(opcode) == S_FETCH);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            // bne takes the branch when the operands differ.
            ctrl.pc_en     = zero ^ is_bne(opcode);
         end
         S_ADDIEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multicycle MIPS datapath: state register + next-state logic.
// Ports: clk, reset (sync, active high), opcode/zero/mem_ready in; datapath enables/selects,
// illegal_op pulse and debug state out. Optional macro CTRL_BNE_EN enables bne.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter bit WAIT_MEM = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] cur_state;
   logic [3:0] next_state;
   logic       mem_rdy;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;

   assign mem_rdy = WAIT_MEM ? mem_ready : 1'b1;

   always_comb begin
      next_state = S_FETCH;
      case (cur_state)
         S_FETCH:    next_state = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE:   next_state = decode_target(opcode);
         S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = mem_rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: next_state = mem_rdy ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  next_state = S_ALUWB;
         S_ADDIEXEC: next_state = S_ADDIWB;
         default:    next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) cur_state <= S_FETCH;
      else       cur_state <= next_state;
   end

   ctrl_output_decode u_decode (
      .state     (cur_state),
      .zero      (zero),
      .mem_ready (mem_rdy),
      .opcode    (opcode),
      .ctrl      (ctrl)
   );

   // Reset masks outputs combinationally so an in-flight memory request drops at once.
   assign ctrl_out   = reset ? '0 : ctrl;
   assign state      = reset ? S_FETCH : cur_state;
   assign pc_en      = ctrl_out.pc_en;
   assign i_or_d     = ctrl_out.i_or_d;
   assign mem_read   = ctrl_out.mem_read;
   assign mem_write  = ctrl_out.mem_write;
   assign ir_write   = ctrl_out.ir_write;
   assign reg_dst    = ctrl_out.reg_dst;
   assign mem_to_reg = ctrl_out.mem_to_reg;
   assign reg_write  = ctrl_out.reg_write;
   assign alu_src_a  = ctrl_out.alu_src_a;
   assign alu_src_b  = ctrl_out.alu_src_b;
   assign alu_op     = ctrl_out.alu_op;
   assign pc_src     = ctrl_out.pc_src;
   assign illegal_op = ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instructions then random ones against a
// path-per-instruction reference model and a per-state output table.
// Output vector order: pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_src,illegal_op.
module tb_multicycle_control_fsm;

`ifdef CTRL_BNE_EN
   localparam bit BNE_ON = 1'b1;
`else
   localparam bit BNE_ON = 1'b0;
`endif

   typedef struct {
      logic [3:0] st;
      logic       mr;
   } step_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .illegal_op(illegal_op), .state(state)
   );

   function automatic logic [15:0] obs_vec();
      return {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
              alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
   endfunction

   function automatic bit op_legal(input logic [5:0] op);
      return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
             op == 6'b001000 || op == 6'b000010 || (BNE_ON && op == 6'b000101);
   endfunction

   // Expected outputs straight from the per-state table.
   function automatic logic [15:0] exp_vec(input logic [3:0] s, input logic mr, input logic z,
                                           input logic [5:0] op);
      logic pe = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 0, ao = 0, ps = 0;
      case (s)
         4'd0:  begin mrd = 1; sb = 2'b01; pe = mr; irw = mr; end
         4'd1:  begin sb = 2'b11; ill = !op_legal(op); end
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin iod = 1; mrd = 1; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin iod = 1; mwr = 1; end
         4'd6:  begin sa = 1; ao = 2'b10; end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z ^ (BNE_ON && op == 6'b000101); end
         4'd9:  begin sa = 1; sb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {pe, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ps, ill};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Runs one instruction: wf wait cycles in FETCH, wm wait cycles in MEMREAD/MEMWRITE.
   task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
      step_t path[$];
      for (int i = 0; i < wf; i++) path.push_back('{4'd0, 1'b0});
      path.push_back('{4'd0, 1'b1});
      path.push_back('{4'd1, rbit()});
      if (op == 6'b100011) begin
         path.push_back('{4'd2, rbit()});
         for (int i = 0; i < wm; i++) path.push_back('{4'd3, 1'b0});
         path.push_back('{4'd3, 1'b1});
         path.push_back('{4'd4, rbit()});
      end else if (op == 6'b101011) begin
         path.push_back('{4'd2, rbit()});
         for (int i = 0; i < wm; i++) path.push_back('{4'd5, 1'b0});
         path.push_back('{4'd5, 1'b1});
      end else if (op == 6'b000000) begin
         path.push_back('{4'd6, rbit()});
         path.push_back('{4'd7, rbit()});
      end else if (op == 6'b000100 || (BNE_ON && op == 6'b000101)) begin
         path.push_back('{4'd8, rbit()});
      end else if (op == 6'b001000) begin
         path.push_back('{4'd9, rbit()});
         path.push_back('{4'd10, rbit()});
      end else if (op == 6'b000010) begin
         path.push_back('{4'd11, rbit()});
      end
      foreach (path[i]) begin
         @(negedge clk);
         opcode = op; zero = z; mem_ready = path[i].mr;
         #1;
         chk($sformatf("state op=%b step=%0d", op, i), {12'd0, state}, {12'd0, path[i].st});
         chk($sformatf("outs op=%b st=%0d", op, path[i].st), obs_vec(),
             exp_vec(path[i].st, path[i].mr, z, op));
         tests++;
         assert (!(reg_write && mem_write)) else begin
            fails++; $error("FAIL inv_rw_mw observed=1 expected=0");
         end
         tests++;
         assert (!pc_en || state == 4'd0 || state == 4'd8 || state == 4'd11) else begin
            fails++; $error("FAIL inv_pc_en state=%0d observed=1 expected=0", state);
         end
      end
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [5:0] op;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
      reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;

      // Reset held two cycles.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         chk("reset_outs", obs_vec(), 16'h0);
         chk("reset_state", {12'd0, state}, 16'h0);
      end
      @(posedge clk); #1 reset = 1'b0;

      run_instr(6'b000000, 1'b0, 0, 0);  // R-type: 0,1,6,7
      run_instr(6'b100011, 1'b0, 0, 2);  // lw with two memory waits
      run_instr(6'b101011, 1'b0, 1, 0);  // sw with one fetch wait
      run_instr(6'b000100, 1'b1, 0, 0);  // beq taken
      run_instr(6'b000100, 1'b0, 0, 0);  // beq not taken
      run_instr(6'b111111, 1'b0, 0, 0);  // illegal
      run_instr(6'b000101, 1'b0, 0, 0);  // bne (legal only with the feature)

      // Reset mid-MEMWRITE while memory stalls.
      @(negedge clk); opcode = 6'b101011; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("mw_state", {12'd0, state}, 16'd5);
      chk("mw_outs", obs_vec(), exp_vec(4'd5, 1'b0, zero, opcode));
      reset = 1'b1; #1;
      chk("mw_reset_outs", obs_vec(), 16'h0);
      @(posedge clk); #1 reset = 1'b0; #1;
      chk("mw_reset_state", {12'd0, state}, 16'd0);
      chk("mw_reset_fetch", obs_vec(), exp_vec(4'd0, 1'b0, zero, opcode));

      // Random instruction mix.
      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
         run_instr(op, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style main controller for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back steps one state per clock. Drives the enables and mux selects, including mem_to_reg for the write-back mux and the register-file write enable. Holds in memory states until the unified instruction/data memory signals ready.

Parameters:
- WAIT_MEM, 1, 1 = honour mem_ready in memory states; 0 = treat mem_ready as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE until the instruction finishes
- zero  in  1  ALU zero flag, combinational in the current cycle
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load enable
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 1 = memory data, 0 = ALU result
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State encoding (4 bits):
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Codes 12–15 are unused; if reached, next state is FETCH.
- Reset: when reset is high at a rising edge, state becomes FETCH regardless of the current state, including mid-instruction and mid-memory-wait.
  - While reset is high, every output is forced to 0, including state's decoded outputs and illegal_op.
- Outputs are decoded from the state only, except pc_en, ir_write and illegal_op as noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write = pc_en = mem_ready.
  - Next: DECODE if mem_ready, else stay in FETCH. PC and IR do not load while waiting.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00.
  - Next by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEXEC
    - 000010 (j) → JUMP
    - any other → FETCH, with illegal_op=1 for this cycle
- MEMADR: alu_src_a=1, alu_src_b=10. Next: MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: i_or_d=1, mem_read=1. Next: MEMWB if mem_ready, else stay.
- MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0. Next: FETCH.
- MEMWRITE: i_or_d=1, mem_write=1. Next: FETCH if mem_ready, else stay with mem_write held high.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero. Next: FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
- ADDIWB: reg_write=1 (reg_dst=0, mem_to_reg=0). Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- Latency with mem_ready constantly 1:
  - 3 cycles: beq, j
  - 4 cycles: R-type, addi, sw
  - 5 cycles: lw
  - Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Invariants:
  - reg_write is never high in the same cycle as mem_write.
  - pc_en is never high outside FETCH, BRANCH and JUMP.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined: opcode 000101 (bne) → BRANCH, and in BRANCH pc_en = zero XOR is_bne, where is_bne is decoded from opcode.
- Undefined: opcode 000101 is illegal; DECODE goes to FETCH and pulses illegal_op.

Decomposition:
- Shared package holds:
  - state localparams/typedef
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - ALUSrcB, ALUOp and PCSrc encodings
  The datapath and ALU decoder reuse these.
- One natural sub-module: ctrl_output_decode, a purely combinational map from (state, zero, mem_ready, opcode) to the output vector.
- The state register and next-state logic stay in the top module.

Test Plan:
- Reset held 2 cycles then released, mem_ready=1, opcode=000000:
  - All outputs are 0 during reset.
  - state sequence 0,1,6,7,0.
  - reg_write=1 and reg_dst=1 only in ALUWB.
- lw (100011) with mem_ready low for 2 cycles in MEMREAD:
  - state sequence 0,1,2,3,3,3,4,0.
  - mem_to_reg=1 and reg_write=1 only in state 4.
- sw (101011) with mem_ready=0 on the first FETCH cycle:
  - FETCH repeats with ir_write=0.
  - In MEMWRITE, mem_write=1 and i_or_d=1 for one cycle.
  - reg_write stays 0 throughout.
- beq (000100) run twice:
  - zero=1 gives pc_en=1 with pc_src=01 in state 8.
  - zero=0 gives pc_en=0 in state 8.
- Illegal opcode 111111 in DECODE: illegal_op pulses for 1 cycle, next state is 0. With CTRL_BNE_EN, 000101 with zero=0 gives pc_en=1 in BRANCH.
- Reset asserted while in MEMWRITE with mem_ready=0: mem_write drops immediately, and state=0 after the next edge.
